// File: rtl/aes128_round_sequencer_if.sv
// Handshake and status bundle for the iterative AES-128 encryption engine.
// The master side offers message/key and consumes the cipher; the slave side is the engine.
interface aes128_round_sequencer_if;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] message;
    logic [0:127] key;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] cipher;
    logic         busy;
    logic [3:0]   round_idx;

    modport master (
        output in_valid, message, key, out_ready,
        input  in_ready, out_valid, cipher, busy, round_idx
    );

    modport slave (
        input  in_valid, message, key, out_ready,
        output in_ready, out_valid, cipher, busy, round_idx
    );
endinterface

// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 encryptor: latches one message/key pair, runs one round per clock
// (initial AddRoundKey, nine full rounds, final round) and holds the cipher until taken.
module aes128_round_sequencer #(
    parameter int NR = 10
) (
    input logic                    clk,
    input logic                    rst,
    aes128_round_sequencer_if.slave bus
);

    if (NR != 10) begin : g_bad_nr
        $error("aes128_round_sequencer supports only NR=10");
    end

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254 by square-and-multiply) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] t;
        logic [7:0] inv;
        t = a;
        for (int i = 0; i < 6; i++) t = gmul(gmul(t, t), a);
        inv = gmul(t, t);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    // Byte index is row + 4*col; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [0:1407] key_expand(input logic [127:0] k);
        logic [31:0]  w [0:43];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [0:1407] ks;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) ks[32*i +: 32] = w[i];
        return ks;
    endfunction

    state_e       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] key_q, key_d;
    logic [127:0] cipher_q, cipher_d;
    logic [3:0]   rnd_q, rnd_d;

    logic [0:1407] ks;
    logic [3:0]    rk_sel;
    logic [127:0]  rk, sr, mc, msg, k_in;

    assign msg    = bus.message;
    assign k_in   = bus.key;
    assign ks     = key_expand(key_q);
    assign rk_sel = (rnd_q > 4'd10) ? 4'd10 : rnd_q;
    assign rk     = ks[128*rk_sel +: 128];
    assign sr     = shift_rows(sub_bytes(st_q));
    assign mc     = mix_columns(sr);

    always_comb begin
        state_d  = state_q;
        st_d     = st_q;
        key_d    = key_q;
        cipher_d = cipher_q;
        rnd_d    = rnd_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    key_d   = k_in;
                    st_d    = msg ^ k_in;
                    rnd_d   = 4'd1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                st_d  = mc ^ rk;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == 4'd9) state_d = FINAL;
            end
            FINAL: begin
                st_d     = sr ^ rk;
                cipher_d = sr ^ rk;
                state_d  = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    rnd_d   = 4'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            st_q     <= '0;
            key_q    <= '0;
            cipher_q <= '0;
            rnd_q    <= '0;
        end else begin
            state_q  <= state_d;
            st_q     <= st_d;
            key_q    <= key_d;
            cipher_q <= cipher_d;
            rnd_q    <= rnd_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == ROUND) || (state_q == FINAL);
    assign bus.round_idx = rnd_q;
    assign bus.cipher    = cipher_q;

endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Directed bench for aes128_round_sequencer using FIPS-197 and textbook AES-128 vectors.
module tb_aes128_round_sequencer;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    localparam logic [0:127] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] M1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] K2 = 128'h5468617473206d79204b756e67204675;
    localparam logic [0:127] M2 = 128'h54776f204f6e65204e696e652054776f;
    localparam logic [0:127] C2 = 128'h29c3505f571420f6402299b31a02d73a;

    aes128_round_sequencer_if bus ();

    aes128_round_sequencer #(.NR(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_accept(input logic [0:127] m, input logic [0:127] k, input bit hold,
                             output int acc, output bit ok);
        bus.message  = m;
        bus.key      = k;
        bus.in_valid = 1'b1;
        ok  = 1'b0;
        acc = -1;
        for (int i = 0; i < 60; i++) begin
            if (bus.in_ready) begin
                tick();
                acc = cyc;
                ok  = 1'b1;
                break;
            end
            tick();
        end
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < 40 && !ok) begin
            if (bus.out_valid) ok = 1'b1;
            else begin
                tick();
                n++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.message = '0;
        bus.key = '0;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.round_idx !== 4'd0) begin n_bad++; $display("FAIL reset_round_idx: got %0d expected 0", bus.round_idx); end
        n_cmp++; if (bus.cipher !== 128'h0) begin n_bad++; $display("FAIL reset_cipher: got %h expected 0", bus.cipher); end
    endtask

    task automatic test_fips_c1();
        int acc, n;
        bit ok;
        bus.out_ready = 1'b1;
        do_accept(M1, K1, 1'b0, acc, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL c1_accept: got %b expected 1", ok); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL c1_busy: got %b expected 1", bus.busy); end
        wait_out(n, ok);
        n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL c1_latency: got %0d expected 10", n); end
        n_cmp++; if (bus.cipher !== C1) begin n_bad++; $display("FAIL c1_cipher: got %h expected %h", bus.cipher, C1); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL c1_pulse: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL c1_in_ready_after: got %b expected 1", bus.in_ready); end
        n_cmp++; if (bus.round_idx !== 4'd0) begin n_bad++; $display("FAIL c1_round_idx_after: got %0d expected 0", bus.round_idx); end
        n_cmp++; if (bus.cipher !== C1) begin n_bad++; $display("FAIL c1_cipher_kept: got %h expected %h", bus.cipher, C1); end
    endtask

    task automatic test_round_walk();
        int acc;
        bit ok;
        bus.out_ready = 1'b1;
        do_accept(M2, K2, 1'b0, acc, ok);
        for (int k = 0; k < 10; k++) begin
            n_cmp++; if (bus.round_idx !== 4'(k + 1)) begin n_bad++; $display("FAIL walk_round_idx[%0d]: got %0d expected %0d", k, bus.round_idx, k + 1); end
            n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL walk_busy[%0d]: got %b expected 1", k, bus.busy); end
            tick();
        end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL walk_out_valid: got %b expected 1", bus.out_valid); end
        n_cmp++; if (bus.round_idx !== 4'd10) begin n_bad++; $display("FAIL walk_done_idx: got %0d expected 10", bus.round_idx); end
        n_cmp++; if (bus.cipher !== C2) begin n_bad++; $display("FAIL walk_cipher: got %h expected %h", bus.cipher, C2); end
        tick();
    endtask

    task automatic test_backpressure();
        int acc, n;
        bit ok;
        bus.out_ready = 1'b0;
        do_accept(M1, K1, 1'b0, acc, ok);
        wait_out(n, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid_seen: got %b expected 1", ok); end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, bus.out_valid); end
            n_cmp++; if (bus.cipher !== C1) begin n_bad++; $display("FAIL bp_cipher[%0d]: got %h expected %h", i, bus.cipher, C1); end
            n_cmp++; if (bus.round_idx !== 4'd10) begin n_bad++; $display("FAIL bp_round_idx[%0d]: got %0d expected 10", i, bus.round_idx); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
        end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_busy_ignore();
        int acc, n;
        bit ok;
        bus.out_ready = 1'b0;
        do_accept(M2, K2, 1'b1, acc, ok);
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) break;
            bus.message = {$urandom, $urandom, $urandom, $urandom};
            bus.key     = {$urandom, $urandom, $urandom, $urandom};
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL busy_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
            tick();
        end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL busy_out_valid: got %b expected 1", bus.out_valid); end
        n_cmp++; if (bus.cipher !== C2) begin n_bad++; $display("FAIL busy_cipher: got %h expected %h", bus.cipher, C2); end
        bus.message   = M1;
        bus.key       = K1;
        bus.out_ready = 1'b1;
        tick();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL busy_idle_ready: got %b expected 1", bus.in_ready); end
        do_accept(M1, K1, 1'b0, acc, ok);
        wait_out(n, ok);
        n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL busy_second_latency: got %0d expected 10", n); end
        n_cmp++; if (bus.cipher !== C1) begin n_bad++; $display("FAIL busy_second_cipher: got %h expected %h", bus.cipher, C1); end
        tick();
    endtask

    task automatic test_reset_mid();
        int acc, n;
        bit ok;
        bus.out_ready = 1'b1;
        do_accept(M1, K1, 1'b0, acc, ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.round_idx == 4'd5) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL mid_reach_round5: got %b expected 1", ok); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_out_valid: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_in_ready: got %b expected 1", bus.in_ready); end
        n_cmp++; if (bus.cipher !== 128'h0) begin n_bad++; $display("FAIL mid_cipher: got %h expected 0", bus.cipher); end
        n_cmp++; if (bus.round_idx !== 4'd0) begin n_bad++; $display("FAIL mid_round_idx: got %0d expected 0", bus.round_idx); end
        do_accept(M1, K1, 1'b0, acc, ok);
        wait_out(n, ok);
        n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL mid_rerun_latency: got %0d expected 10", n); end
        n_cmp++; if (bus.cipher !== C1) begin n_bad++; $display("FAIL mid_rerun_cipher: got %h expected %h", bus.cipher, C1); end
        tick();
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, n;
        bit ok;
        bus.out_ready = 1'b1;
        do_accept(M1, K1, 1'b1, acc1, ok);
        bus.message = M2;
        bus.key     = K2;
        wait_out(n, ok);
        n_cmp++; if (bus.cipher !== C1) begin n_bad++; $display("FAIL b2b_first_cipher: got %h expected %h", bus.cipher, C1); end
        do_accept(M2, K2, 1'b0, acc2, ok);
        n_cmp++; if (acc2 - acc1 !== 12) begin n_bad++; $display("FAIL b2b_spacing: got %0d expected 12", acc2 - acc1); end
        wait_out(n, ok);
        n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL b2b_second_latency: got %0d expected 10", n); end
        n_cmp++; if (bus.cipher !== C2) begin n_bad++; $display("FAIL b2b_second_cipher: got %h expected %h", bus.cipher, C2); end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.message   = '0;
        bus.key       = '0;
        test_reset();
        test_fips_c1();
        test_round_walk();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
